playfield_store: RTL and testbench
==================================

# playfield_store

Holds the 10×20 Tetris playfield and answers the display's per-pixel cell lookups. The display drives `tetris_x`/`tetris_y` and receives `kind`, which already includes the falling-piece overlay. The block also locks pieces into the board, clears full rows with a shift-down FSM, and keeps the 4-digit BCD `tetris_score` shown on the scoreboard. It sits between the game controller and the display.

## Interface
- `COLS`, 10, playfield width in cells
- `ROWS`, 20, playfield height in cells
- `clk`  in  1  system clock, same as display
- `reset_n`  in  1  asynchronous active-low reset
- `tetris_x`, `tetris_y`  in  5 each  display lookup cell (x 0..9, y 0..19)
- `kind`  out  4  registered cell content for lookup; 0 = empty, 1..7 = piece kinds
- `piece_valid`  in  1  falling piece is on screen
- `piece_kind`  in  4  falling piece kind, 1..7
- `piece_x [0:3]`, `piece_y [0:3]`  in  5 each  falling piece cell coordinates
- `lock_req`  in  1  one-cycle pulse: write the piece cells into the board
- `clear_req`  in  1  one-cycle pulse: empty the board and zero the score (new game)
- `q_x [0:3]`, `q_y [0:3]`  in  5 each  collision query cells
- `q_hit`  out  1  registered: any query cell is out of bounds or occupied
- `busy`  out  1  lock/clear sequence in progress
- `done`  out  1  one-cycle pulse when the lock sequence finishes
- `lines`  out  3  rows cleared by the last lock, 0..4, valid from `done` onward
- `tetris_score`  out  16  4 BCD digits; [15:12] is the most significant digit

## Operation
- Storage: `ROWS` registers, each `COLS`×3 bits; a cell holds a kind from 0 to 7.
- Lookup:
  - If `piece_valid` and (`tetris_x`,`tetris_y`) equals any piece cell, `kind` = `piece_kind`.
  - Otherwise, `kind` = the stored cell value.
  - Any coordinate with x≥`COLS` or y≥`ROWS` returns 0.
  - Lookup is served in every state, including during a clear. Mid-shift content is displayed as-is.
- Query: `q_hit` = OR over the four query cells of (x≥`COLS` | y≥`ROWS` | cell≠0). The query reads the stored board only and ignores the overlay.
- FSM states:
  - IDLE: `busy`=0. `clear_req` zeroes all rows and the score in one cycle. Otherwise `lock_req` goes to WRITE. If both are asserted in the same cycle, `clear_req` wins.
  - WRITE: write `piece_kind` into the four piece cells sampled at the accepting edge. Out-of-range cells are dropped. Set r=`ROWS`-1 and line count = 0. Go to SCAN.
  - SCAN: test row r.
    - If every cell is nonzero: increment the line count, set ptr=r, go to SHIFT.
    - Else if r==0: go to DONE.
    - Else: r←r−1 and stay in SCAN.
  - SHIFT: each cycle, row[ptr]←row[ptr−1] and ptr←ptr−1. When ptr==0, row[0]←0 and the FSM returns to SCAN with the same r, so the row is rescanned.
  - DONE: `done`=1 and `lines`←count. Add count to `tetris_score` as a BCD ripple add; the score saturates at 9999. Return to IDLE.
- `lock_req` and `clear_req` are ignored while `busy`=1.
- `lines` holds its value until the next DONE.

## Timing
- `kind` and `q_hit` have 1-cycle latency: inputs sampled at edge N appear after edge N.
- Lock sequence, counting from the accepting edge:
  - WRITE takes 1 cycle.
  - Each row scan takes 1 cycle.
  - Each cleared row at index r costs r+1 SHIFT cycles plus 1 rescan cycle.
  - DONE takes 1 cycle.
- A lock with no full row pulses `done` 22 cycles after acceptance.
- `busy` rises on the cycle after acceptance and falls in the cycle after DONE.
- Reset values:
  - Board all 0.
  - `kind`=0, `q_hit`=0, `busy`=0, `done`=0, `lines`=0, `tetris_score`=16'h0000.
  - FSM in IDLE.
- Reset asserted mid-sequence: everything returns to the reset values immediately (asynchronous). No partial score is committed.

## Structure
- Shared package: `COLS`, `ROWS`, kind encoding (`KIND_EMPTY`=0), and the FSM state enum.
- One sub-module is natural: `bcd_add4`, a 4-digit BCD plus 0..4 add with saturation to 9999.

## Test plan
- Reset, then look up (3,5) → `kind`=0. Assert `piece_valid` with kind 2 at cells (3,5),(4,5),(5,5),(4,6), look up (4,6) → `kind`=2 one cycle later.
- Lock an I piece (kind 1) at row 19, cols 0..3 with the rest of the board empty:
  - `done` pulses 22 cycles after acceptance, `lines`=0, score 0000.
  - Lookup (2,19) → 1.
- Fill row 19 cols 0..5 and 9 beforehand, lock a piece completing cols 6..8, with row 18 holding kind 3 at col 0:
  - `lines`=1 and score 0001.
  - Row 19 col 0 reads 3, row 0 is empty.
  - `done` pulses 43 cycles after acceptance.
- Prefill rows 16..19 so that one I-piece lock completes all four rows → `lines`=4, score +4, all four rows empty after `done`.
- Preload score 9998 and clear 2 lines → score 9999. Assert `clear_req` in IDLE → score 0000 and board empty next cycle.
- Query cell (10,0) → `q_hit`=1.
- Assert `lock_req` while `busy` → ignored, board unchanged.
- Assert `reset_n` low mid-SHIFT → all outputs at reset values immediately.

Source files
------------

// File: rtl/playfield_store_pkg.sv
// Shared playfield geometry, cell encoding and lock/clear FSM states.
package playfield_store_pkg;

  localparam int COLS   = 10;
  localparam int ROWS   = 20;
  localparam int CELL_W = 3;
  localparam int ROW_W  = COLS * CELL_W;

  localparam logic [4:0]  X_LIM      = 5'(COLS);
  localparam logic [4:0]  Y_LIM      = 5'(ROWS);
  localparam logic [4:0]  LAST_ROW   = 5'(ROWS - 1);
  localparam logic [2:0]  KIND_EMPTY = 3'd0;
  localparam logic [15:0] SCORE_MAX  = 16'h9999;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_SCAN,
    ST_SHIFT,
    ST_DONE
  } state_t;

  function automatic logic row_is_full(input logic [ROW_W-1:0] row);
    logic full;
    full = 1'b1;
    for (int c = 0; c < COLS; c++) begin
      if (row[c*CELL_W +: CELL_W] == KIND_EMPTY) full = 1'b0;
    end
    return full;
  endfunction

endpackage

// File: rtl/playfield_store_if.sv
// Controller/display side of the playfield store.
// lock_req and clear_req are single-cycle pulses taken only while busy is low;
// done pulses for one cycle at the end of a lock and lines is valid from then on.
interface playfield_store_if;

  logic [4:0]  tetris_x;
  logic [4:0]  tetris_y;
  logic [3:0]  kind;
  logic        piece_valid;
  logic [3:0]  piece_kind;
  logic [4:0]  piece_x [0:3];
  logic [4:0]  piece_y [0:3];
  logic        lock_req;
  logic        clear_req;
  logic [4:0]  q_x [0:3];
  logic [4:0]  q_y [0:3];
  logic        q_hit;
  logic        busy;
  logic        done;
  logic [2:0]  lines;
  logic [15:0] tetris_score;

  modport master (
    output tetris_x, tetris_y, piece_valid, piece_kind, piece_x, piece_y,
           lock_req, clear_req, q_x, q_y,
    input  kind, q_hit, busy, done, lines, tetris_score
  );

  modport slave (
    input  tetris_x, tetris_y, piece_valid, piece_kind, piece_x, piece_y,
           lock_req, clear_req, q_x, q_y,
    output kind, q_hit, busy, done, lines, tetris_score
  );

endinterface

// File: rtl/playfield_store_bcd_add4.sv
// Four-digit BCD score plus a 0..4 line count, saturating at 9999.
module bcd_add4
  import playfield_store_pkg::*;
(
  input  logic [15:0] score,
  input  logic [2:0]  add,
  output logic [15:0] sum
);

  logic [4:0]  acc;
  logic [15:0] res;
  logic        carry;

  always_comb begin
    acc   = '0;
    res   = '0;
    carry = 1'b0;
    for (int i = 0; i < 4; i++) begin
      acc = {1'b0, score[i*4 +: 4]} + ((i == 0) ? {2'b00, add} : {4'b0000, carry});
      carry = (acc > 5'd9);
      res[i*4 +: 4] = carry ? 4'(acc - 5'd10) : acc[3:0];
    end
    sum = carry ? SCORE_MAX : res;
  end

endmodule

// File: rtl/playfield_store.sv
// 10x20 playfield: pixel lookup with piece overlay, collision query,
// piece locking with row clear/shift-down and BCD scoring.
module playfield_store
  import playfield_store_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  playfield_store_if.slave  bus,
  output state_t            dbg_state
);

  logic [ROW_W-1:0] rows [ROWS];
  state_t           state;
  state_t           state_nx;
  logic [4:0]       r;
  logic [4:0]       ptr;
  logic [2:0]       count;
  logic [2:0]       lock_kind;
  logic [4:0]       lock_x [4];
  logic [4:0]       lock_y [4];
  logic [3:0]       kind_q;
  logic [3:0]       kind_nx;
  logic             q_hit_q;
  logic             q_hit_nx;
  logic             overlay;
  logic [2:0]       lines_q;
  logic [15:0]      score_q;
  logic [15:0]      score_sum;
  logic [ROW_W-1:0] scan_row;
  logic             row_full;

  function automatic logic [2:0] cell_at(input logic [4:0] x, input logic [4:0] y);
    logic [2:0] v;
    v = KIND_EMPTY;
    for (int yy = 0; yy < ROWS; yy++) begin
      for (int c = 0; c < COLS; c++) begin
        if (y == 5'(yy) && x == 5'(c)) v = rows[yy][c*CELL_W +: CELL_W];
      end
    end
    return v;
  endfunction

  always_comb begin
    scan_row = '0;
    for (int y = 0; y < ROWS; y++) begin
      if (r == 5'(y)) scan_row = rows[y];
    end
    row_full = row_is_full(scan_row);
  end

  // Lookup sees the overlay; the collision query deliberately does not.
  always_comb begin
    kind_nx  = '0;
    overlay  = 1'b0;
    q_hit_nx = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (bus.piece_x[i] == bus.tetris_x && bus.piece_y[i] == bus.tetris_y) overlay = 1'b1;
    end
    if (bus.tetris_x >= X_LIM || bus.tetris_y >= Y_LIM) kind_nx = 4'd0;
    else if (bus.piece_valid && overlay)               kind_nx = bus.piece_kind;
    else                                               kind_nx = {1'b0, cell_at(bus.tetris_x, bus.tetris_y)};
    for (int i = 0; i < 4; i++) begin
      if (bus.q_x[i] >= X_LIM || bus.q_y[i] >= Y_LIM ||
          cell_at(bus.q_x[i], bus.q_y[i]) != KIND_EMPTY) q_hit_nx = 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:  if (!bus.clear_req && bus.lock_req) state_nx = ST_WRITE;
      ST_WRITE: state_nx = ST_SCAN;
      ST_SCAN: begin
        if (row_full)      state_nx = ST_SHIFT;
        else if (r == '0)  state_nx = ST_DONE;
      end
      ST_SHIFT: if (ptr == '0) state_nx = ST_SCAN;
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      r         <= '0;
      ptr       <= '0;
      count     <= '0;
      lines_q   <= '0;
      score_q   <= '0;
      lock_kind <= '0;
      kind_q    <= '0;
      q_hit_q   <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        lock_x[i] <= '0;
        lock_y[i] <= '0;
      end
    end else begin
      state   <= state_nx;
      kind_q  <= kind_nx;
      q_hit_q <= q_hit_nx;
      case (state)
        ST_IDLE: begin
          if (bus.clear_req) begin
            score_q <= '0;
          end else if (bus.lock_req) begin
            lock_kind <= bus.piece_kind[2:0];
            for (int i = 0; i < 4; i++) begin
              lock_x[i] <= bus.piece_x[i];
              lock_y[i] <= bus.piece_y[i];
            end
          end
        end
        ST_WRITE: begin
          r     <= LAST_ROW;
          count <= '0;
        end
        ST_SCAN: begin
          if (row_full) begin
            count <= count + 3'd1;
            ptr   <= r;
          end else if (r == '0) begin
            lines_q <= count;
          end else begin
            r <= r - 5'd1;
          end
        end
        // ptr wraps after the last shift; SCAN reloads it before any reuse.
        ST_SHIFT: ptr <= ptr - 5'd1;
        ST_DONE:  score_q <= score_sum;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int y = 0; y < ROWS; y++) rows[y] <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.clear_req) begin
            for (int y = 0; y < ROWS; y++) rows[y] <= '0;
          end
        end
        ST_WRITE: begin
          // Cells outside the board never match an index and are dropped.
          for (int i = 0; i < 4; i++) begin
            for (int y = 0; y < ROWS; y++) begin
              for (int c = 0; c < COLS; c++) begin
                if (lock_y[i] == 5'(y) && lock_x[i] == 5'(c))
                  rows[y][c*CELL_W +: CELL_W] <= lock_kind;
              end
            end
          end
        end
        ST_SHIFT: begin
          for (int y = 1; y < ROWS; y++) begin
            if (ptr == 5'(y)) rows[y] <= rows[y-1];
          end
          if (ptr == '0) rows[0] <= '0;
        end
        default: ;
      endcase
    end
  end

  bcd_add4 u_bcd_add4 (
    .score (score_q),
    .add   (count),
    .sum   (score_sum)
  );

  assign bus.kind         = kind_q;
  assign bus.q_hit        = q_hit_q;
  assign bus.busy         = (state != ST_IDLE);
  assign bus.done         = (state == ST_DONE);
  assign bus.lines        = lines_q;
  assign bus.tetris_score = score_q;
  assign dbg_state        = state;

endmodule

// File: tb/tb_playfield_store.sv
// Scenario bench for playfield_store: lookup, query, lock/clear timing and scoring.
module tb_playfield_store;
  import playfield_store_pkg::*;

  logic        clk;
  logic        reset_n;
  state_t      dbg_state;
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q[$];
  logic [15:0] bcd_in;
  logic [2:0]  bcd_add;
  logic [15:0] bcd_sum;

  playfield_store_if bus ();

  playfield_store dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  bcd_add4 u_bcd (
    .score (bcd_in),
    .add   (bcd_add),
    .sum   (bcd_sum)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  function automatic logic [19:0] pack4(input logic [4:0] a, input logic [4:0] b,
                                        input logic [4:0] c, input logic [4:0] d);
    return {d, c, b, a};
  endfunction

  task automatic idle_inputs();
    bus.tetris_x    = '0;
    bus.tetris_y    = '0;
    bus.piece_valid = 1'b0;
    bus.piece_kind  = '0;
    bus.lock_req    = 1'b0;
    bus.clear_req   = 1'b0;
    bcd_in          = '0;
    bcd_add         = '0;
    for (int i = 0; i < 4; i++) begin
      bus.piece_x[i] = '0;
      bus.piece_y[i] = '0;
      bus.q_x[i]     = '0;
      bus.q_y[i]     = '0;
    end
  endtask

  task automatic set_piece(input logic [3:0] k, input logic [19:0] xs, input logic [19:0] ys);
    bus.piece_kind = k;
    for (int i = 0; i < 4; i++) begin
      bus.piece_x[i] = xs[i*5 +: 5];
      bus.piece_y[i] = ys[i*5 +: 5];
    end
  endtask

  task automatic set_query(input logic [19:0] xs, input logic [19:0] ys);
    for (int i = 0; i < 4; i++) begin
      bus.q_x[i] = xs[i*5 +: 5];
      bus.q_y[i] = ys[i*5 +: 5];
    end
  endtask

  // Called at a negedge; returns at the negedge of the cycle after acceptance.
  task automatic drive_lock(input logic [3:0] k, input logic [19:0] xs, input logic [19:0] ys);
    set_piece(k, xs, ys);
    bus.lock_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.lock_req = 1'b0;
  endtask

  // Counts cycles (current one is 1) until done is seen; -1 if it never comes.
  task automatic wait_done(output int cycles);
    cycles = 1;
    while (bus.done !== 1'b1 && cycles < 400) begin
      @(negedge clk);
      cycles++;
    end
    if (bus.done !== 1'b1) cycles = -1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [15:0] e;
    idle_inputs();
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.kind !== 4'd0 || bus.q_hit !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: kind=%0d q_hit=%0b busy=%0b done=%0b, required 0 0 0 0",
               bus.kind, bus.q_hit, bus.busy, bus.done);
    end
    checks++;
    if (bus.lines !== 3'd0 || bus.tetris_score !== 16'h0000 || dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_regs: lines=%0d score=%h state=%0d, required 0 0000 IDLE",
               bus.lines, bus.tetris_score, dbg_state);
    end
    reset_n = 1'b1;
    bus.tetris_x = 5'd3;
    bus.tetris_y = 5'd5;
    exp_q.push_back(16'd0);
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (bus.kind !== e[3:0]) begin
      errors++;
      $display("FAIL reset_lookup: kind=%0d required %0d", bus.kind, e[3:0]);
    end
  endtask

  task automatic test_lookup();
    logic [4:0]  lx [6];
    logic [4:0]  ly [6];
    logic [3:0]  lk [6];
    logic        pv [6];
    logic [15:0] e;
    lx = '{5'd4, 5'd3, 5'd6, 5'd4, 5'd4, 5'd12};
    ly = '{5'd6, 5'd5, 5'd5, 5'd5, 5'd6, 5'd5};
    lk = '{4'd2, 4'd2, 4'd0, 4'd2, 4'd0, 4'd0};
    pv = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    set_piece(4'd2, pack4(5'd3, 5'd4, 5'd5, 5'd4), pack4(5'd5, 5'd5, 5'd5, 5'd6));
    for (int i = 0; i < 6; i++) begin
      // The last entry puts a piece cell off-board to show it is never overlaid.
      if (i == 5) bus.piece_x[0] = 5'd12;
      bus.piece_valid = pv[i];
      bus.tetris_x = lx[i];
      bus.tetris_y = ly[i];
      exp_q.push_back({12'd0, lk[i]});
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (bus.kind !== e[3:0]) begin
        errors++;
        $display("FAIL lookup_%0d: kind=%0d required %0d at (%0d,%0d)", i, bus.kind, e[3:0], lx[i], ly[i]);
      end
    end
    bus.piece_valid = 1'b0;
  endtask

  task automatic test_lock_no_lines();
    logic [15:0] e;
    int          cyc;
    exp_q.push_back(16'd0);
    exp_q.push_back(16'h0000);
    drive_lock(4'd1, pack4(5'd0, 5'd1, 5'd2, 5'd3), pack4(5'd19, 5'd19, 5'd19, 5'd19));
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL i_busy_rise: busy=%0b required 1", bus.busy);
    end
    wait_done(cyc);
    checks++;
    if (cyc != 22) begin
      errors++;
      $display("FAIL i_done_latency: %0d cycles, required 22", cyc);
    end
    e = exp_q.pop_front();
    checks++;
    if (bus.lines !== e[2:0]) begin
      errors++;
      $display("FAIL i_lines: lines=%0d required %0d", bus.lines, e[2:0]);
    end
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (bus.tetris_score !== e) begin
      errors++;
      $display("FAIL i_score: score=%h required %h", bus.tetris_score, e);
    end
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL i_after_done: done=%0b busy=%0b required 0 0", bus.done, bus.busy);
    end
    for (int i = 0; i < 3; i++) begin
      bus.tetris_x = (i == 0) ? 5'd2 : ((i == 1) ? 5'd4 : 5'd0);
      bus.tetris_y = (i == 2) ? 5'd18 : 5'd19;
      exp_q.push_back((i == 0) ? 16'd1 : 16'd0);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (bus.kind !== e[3:0]) begin
        errors++;
        $display("FAIL i_board_%0d: kind=%0d required %0d", i, bus.kind, e[3:0]);
      end
    end
  endtask

  task automatic test_one_line();
    logic [15:0] e;
    int          cyc;
    logic [4:0]  lx [5];
    logic [4:0]  ly [5];
    logic [3:0]  lk [5];
    // Fill row 19 cols 4,5,9 and put kind 3 at (0,18).
    exp_q.push_back(16'd0);
    exp_q.push_back(16'h0000);
    drive_lock(4'd3, pack4(5'd4, 5'd5, 5'd9, 5'd0), pack4(5'd19, 5'd19, 5'd19, 5'd18));
    wait_done(cyc);
    checks++;
    if (cyc != 22) begin
      errors++;
      $display("FAIL fill_latency: %0d cycles, required 22", cyc);
    end
    e = exp_q.pop_front();
    checks++;
    if (bus.lines !== e[2:0]) begin
      errors++;
      $display("FAIL fill_lines: lines=%0d required %0d", bus.lines, e[2:0]);
    end
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (bus.tetris_score !== e) begin
      errors++;
      $display("FAIL fill_score: score=%h required %h", bus.tetris_score, e);
    end
    // Complete row 19; the fourth cell is off-board and must be dropped.
    exp_q.push_back(16'd1);
    exp_q.push_back(16'h0001);
    drive_lock(4'd5, pack4(5'd6, 5'd7, 5'd8, 5'd12), pack4(5'd19, 5'd19, 5'd19, 5'd0));
    wait_done(cyc);
    checks++;
    if (cyc != 43) begin
      errors++;
      $display("FAIL one_line_latency: %0d cycles, required 43", cyc);
    end
    e = exp_q.pop_front();
    checks++;
    if (bus.lines !== e[2:0]) begin
      errors++;
      $display("FAIL one_line_lines: lines=%0d required %0d", bus.lines, e[2:0]);
    end
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (bus.tetris_score !== e) begin
      errors++;
      $display("FAIL one_line_score: score=%h required %h", bus.tetris_score, e);
    end
    lx = '{5'd0, 5'd0, 5'd4, 5'd0, 5'd6};
    ly = '{5'd19, 5'd0, 5'd19, 5'd18, 5'd19};
    lk = '{4'd3, 4'd0, 4'd0, 4'd0, 4'd0};
    for (int i = 0; i < 5; i++) begin
      bus.tetris_x = lx[i];
      bus.tetris_y = ly[i];
      exp_q.push_back({12'd0, lk[i]});
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (bus.kind !== e[3:0]) begin
        errors++;
        $display("FAIL one_line_board_%0d: kind=%0d required %0d", i, bus.kind, e[3:0]);
      end
    end
  endtask

  task automatic test_query();
    logic [19:0] qx [5];
    logic [19:0] qy [5];
    logic        qe [5];
    logic [15:0] e;
    // Board now holds only kind 3 at (0,19).
    qx[0] = pack4(5'd10, 5'd0, 5'd1, 5'd2);  qy[0] = pack4(5'd0, 5'd0, 5'd0, 5'd0);   qe[0] = 1'b1;
    qx[1] = pack4(5'd0, 5'd1, 5'd2, 5'd3);   qy[1] = pack4(5'd0, 5'd0, 5'd0, 5'd0);   qe[1] = 1'b0;
    qx[2] = pack4(5'd5, 5'd0, 5'd1, 5'd2);   qy[2] = pack4(5'd5, 5'd19, 5'd1, 5'd2);  qe[2] = 1'b1;
    qx[3] = pack4(5'd1, 5'd2, 5'd3, 5'd1);   qy[3] = pack4(5'd19, 5'd19, 5'd19, 5'd18); qe[3] = 1'b0;
    qx[4] = pack4(5'd0, 5'd1, 5'd2, 5'd3);   qy[4] = pack4(5'd20, 5'd0, 5'd0, 5'd0);  qe[4] = 1'b1;
    // A visible piece on the queried cells must not count as occupied.
    set_piece(4'd4, pack4(5'd0, 5'd1, 5'd2, 5'd3), pack4(5'd0, 5'd0, 5'd0, 5'd0));
    bus.piece_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_query(qx[i], qy[i]);
      exp_q.push_back({15'd0, qe[i]});
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (bus.q_hit !== e[0]) begin
        errors++;
        $display("FAIL query_%0d: q_hit=%0b required %0b", i, bus.q_hit, e[0]);
      end
    end
    bus.piece_valid = 1'b0;
    set_query(pack4(5'd0, 5'd0, 5'd0, 5'd0), pack4(5'd0, 5'd0, 5'd0, 5'd0));
  endtask

  task automatic test_clear();
    logic [15:0] e;
    // clear_req and lock_req together: clear wins and no lock starts.
    set_piece(4'd7, pack4(5'd0, 5'd1, 5'd2, 5'd3), pack4(5'd5, 5'd5, 5'd5, 5'd5));
    bus.clear_req = 1'b1;
    bus.lock_req  = 1'b1;
    exp_q.push_back(16'h0000);
    @(negedge clk);
    bus.clear_req = 1'b0;
    bus.lock_req  = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (bus.tetris_score !== e) begin
      errors++;
      $display("FAIL clear_score: score=%h required %h", bus.tetris_score, e);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL clear_wins: busy=%0b required 0", bus.busy);
    end
    checks++;
    if (bus.lines !== 3'd1) begin
      errors++;
      $display("FAIL clear_lines_hold: lines=%0d required 1", bus.lines);
    end
    for (int i = 0; i < 2; i++) begin
      bus.tetris_x = 5'd0;
      bus.tetris_y = (i == 0) ? 5'd19 : 5'd5;
      exp_q.push_back(16'd0);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (bus.kind !== e[3:0]) begin
        errors++;
        $display("FAIL clear_board_%0d: kind=%0d required %0d", i, bus.kind, e[3:0]);
      end
    end
  endtask

  task automatic test_four_lines();
    logic [15:0] e;
    int          cyc;
    logic [19:0] xs;
    logic [19:0] ys;
    int          col;
    // Rows 16..19 filled everywhere except column 4, four cells per lock.
    for (int li = 0; li < 9; li++) begin
      xs = '0;
      ys = '0;
      for (int j = 0; j < 4; j++) begin
        col = (li*4 + j) % 9;
        if (col >= 4) col++;
        xs[j*5 +: 5] = 5'(col);
        ys[j*5 +: 5] = 5'(16 + (li*4 + j) / 9);
      end
      exp_q.push_back(16'd0);
      exp_q.push_back(16'h0000);
      drive_lock(4'((li % 7) + 1), xs, ys);
      wait_done(cyc);
      checks++;
      if (cyc != 22) begin
        errors++;
        $display("FAIL prefill_%0d_latency: %0d cycles, required 22", li, cyc);
      end
      e = exp_q.pop_front();
      checks++;
      if (bus.lines !== e[2:0]) begin
        errors++;
        $display("FAIL prefill_%0d_lines: lines=%0d required %0d", li, bus.lines, e[2:0]);
      end
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (bus.tetris_score !== e) begin
        errors++;
        $display("FAIL prefill_%0d_score: score=%h required %h", li, bus.tetris_score, e);
      end
    end
    // Vertical I in column 4: 1 + 1 + 4*(20+1) + 19 + 1 = 106 cycles.
    exp_q.push_back(16'd4);
    exp_q.push_back(16'h0004);
    drive_lock(4'd1, pack4(5'd4, 5'd4, 5'd4, 5'd4), pack4(5'd16, 5'd17, 5'd18, 5'd19));
    wait_done(cyc);
    checks++;
    if (cyc != 106) begin
      errors++;
      $display("FAIL four_latency: %0d cycles, required 106", cyc);
    end
    e = exp_q.pop_front();
    checks++;
    if (bus.lines !== e[2:0]) begin
      errors++;
      $display("FAIL four_lines: lines=%0d required %0d", bus.lines, e[2:0]);
    end
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (bus.tetris_score !== e) begin
      errors++;
      $display("FAIL four_score: score=%h required %h", bus.tetris_score, e);
    end
    for (int i = 0; i < 4; i++) begin
      bus.tetris_x = 5'($urandom_range(0, 9));
      bus.tetris_y = 5'(16 + i);
      exp_q.push_back(16'd0);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (bus.kind !== e[3:0]) begin
        errors++;
        $display("FAIL four_board_row%0d: kind=%0d required %0d", 16 + i, bus.kind, e[3:0]);
      end
    end
  endtask

  task automatic test_busy_ignore();
    logic [15:0] e;
    int          cyc;
    exp_q.push_back(16'd0);
    exp_q.push_back(16'h0004);
    drive_lock(4'd6, pack4(5'd0, 5'd1, 5'd2, 5'd3), pack4(5'd0, 5'd0, 5'd0, 5'd0));
    @(negedge clk);
    @(negedge clk);
    set_piece(4'd4, pack4(5'd5, 5'd6, 5'd7, 5'd8), pack4(5'd0, 5'd0, 5'd0, 5'd0));
    bus.lock_req  = 1'b1;
    bus.clear_req = 1'b1;
    @(negedge clk);
    bus.lock_req  = 1'b0;
    bus.clear_req = 1'b0;
    wait_done(cyc);
    checks++;
    if (cyc != 19) begin
      errors++;
      $display("FAIL busy_latency: %0d remaining cycles, required 19", cyc);
    end
    e = exp_q.pop_front();
    checks++;
    if (bus.lines !== e[2:0]) begin
      errors++;
      $display("FAIL busy_lines: lines=%0d required %0d", bus.lines, e[2:0]);
    end
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (bus.tetris_score !== e) begin
      errors++;
      $display("FAIL busy_score: score=%h required %h", bus.tetris_score, e);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_no_relock: busy=%0b required 0", bus.busy);
    end
    for (int i = 0; i < 3; i++) begin
      bus.tetris_x = (i == 0) ? 5'd0 : ((i == 1) ? 5'd5 : 5'd8);
      bus.tetris_y = 5'd0;
      exp_q.push_back((i == 0) ? 16'd6 : 16'd0);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (bus.kind !== e[3:0]) begin
        errors++;
        $display("FAIL busy_board_%0d: kind=%0d required %0d", i, bus.kind, e[3:0]);
      end
    end
  endtask

  task automatic test_bcd_saturate();
    logic [15:0] si [9];
    logic [2:0]  ai [9];
    logic [15:0] so [9];
    logic [15:0] e;
    si = '{16'h9998, 16'h9999, 16'h0999, 16'h0009, 16'h1234, 16'h9996, 16'h9995, 16'h0019, 16'h9989};
    ai = '{3'd2,     3'd4,     3'd1,     3'd4,     3'd0,     3'd3,     3'd4,     3'd1,     3'd4};
    so = '{16'h9999, 16'h9999, 16'h1000, 16'h0013, 16'h1234, 16'h9999, 16'h9999, 16'h0020, 16'h9993};
    for (int i = 0; i < 9; i++) begin
      bcd_in  = si[i];
      bcd_add = ai[i];
      exp_q.push_back(so[i]);
      #1;
      e = exp_q.pop_front();
      checks++;
      if (bcd_sum !== e) begin
        errors++;
        $display("FAIL bcd_%0d: %h+%0d gave %h, required %h", i, si[i], ai[i], bcd_sum, e);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_shift();
    logic [15:0] e;
    int          cyc;
    int          n;
    exp_q.push_back(16'd0);
    exp_q.push_back(16'h0004);
    drive_lock(4'd2, pack4(5'd4, 5'd5, 5'd6, 5'd7), pack4(5'd0, 5'd0, 5'd0, 5'd0));
    wait_done(cyc);
    e = exp_q.pop_front();
    checks++;
    if (cyc != 22 || bus.lines !== e[2:0]) begin
      errors++;
      $display("FAIL pre_shift_lock: cycles=%0d lines=%0d, required 22 %0d", cyc, bus.lines, e[2:0]);
    end
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (bus.tetris_score !== e) begin
      errors++;
      $display("FAIL pre_shift_score: score=%h required %h", bus.tetris_score, e);
    end
    bus.tetris_x = 5'd0;
    bus.tetris_y = 5'd0;
    set_query(pack4(5'd10, 5'd10, 5'd10, 5'd10), pack4(5'd0, 5'd0, 5'd0, 5'd0));
    drive_lock(4'd2, pack4(5'd8, 5'd9, 5'd15, 5'd3), pack4(5'd0, 5'd0, 5'd3, 5'd25));
    n = 0;
    while (dbg_state !== ST_SHIFT && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (dbg_state !== ST_SHIFT) begin
      errors++;
      $display("FAIL reach_shift: state=%0d after %0d cycles, required SHIFT", dbg_state, n);
    end
    checks++;
    if (bus.kind !== 4'd6 || bus.q_hit !== 1'b1 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset: kind=%0d q_hit=%0b busy=%0b, required 6 1 1", bus.kind, bus.q_hit, bus.busy);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (bus.kind !== 4'd0 || bus.q_hit !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_flags: kind=%0d q_hit=%0b busy=%0b done=%0b, required 0 0 0 0",
               bus.kind, bus.q_hit, bus.busy, bus.done);
    end
    checks++;
    if (bus.lines !== 3'd0 || bus.tetris_score !== 16'h0000 || dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL async_reset_regs: lines=%0d score=%h state=%0d, required 0 0000 IDLE",
               bus.lines, bus.tetris_score, dbg_state);
    end
    @(negedge clk);
    reset_n = 1'b1;
    set_query(pack4(5'd0, 5'd1, 5'd8, 5'd9), pack4(5'd0, 5'd0, 5'd0, 5'd0));
    for (int i = 0; i < 2; i++) begin
      bus.tetris_x = (i == 0) ? 5'd0 : 5'd9;
      bus.tetris_y = 5'd0;
      exp_q.push_back(16'd0);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (bus.kind !== e[3:0] || bus.q_hit !== 1'b0) begin
        errors++;
        $display("FAIL post_reset_board_%0d: kind=%0d q_hit=%0b, required %0d 0", i, bus.kind, bus.q_hit, e[3:0]);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_lookup();
    test_lock_no_lines();
    test_one_line();
    test_query();
    test_clear();
    test_four_lines();
    test_busy_ignore();
    test_bcd_saturate();
    test_reset_mid_shift();
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
